// File: rtl/bist_misr_ctrl.sv
// rtl/bist_misr_ctrl.sv - BIST response MISR with golden compare
// Optional serial signature readout is built when MISR_SHIFTOUT_EN is defined.
module bist_misr_ctrl #(
    parameter int unsigned         WIDTH        = 39,
    parameter int unsigned         NUM_PATTERNS = 256,
    parameter logic [WIDTH-1:0]    POLY         = 39'h40_0000_0011,
    parameter logic [WIDTH-1:0]    SEED         = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] resp_in,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] golden,
    output logic             lfsr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    input  logic             sig_shift,
    input  logic             sig_tdi,
    output logic             sig_tdo
);

    localparam int unsigned CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             lfsr_en_q;
    logic             shift_req;
    logic [WIDTH-1:0] shift_d;

    // Shift-left MISR step with the response folded in after feedback
    always_comb begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_in;
    end

`ifdef MISR_SHIFTOUT_EN
    assign shift_req = sig_shift;
    assign shift_d   = {sig_q[WIDTH-2:0], sig_tdi};
    assign sig_tdo   = sig_q[WIDTH-1];
`else
    logic unused_shift_pins;
    assign unused_shift_pins = sig_shift ^ sig_tdi;
    assign shift_req = 1'b0;
    assign shift_d   = sig_q;
    assign sig_tdo   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sig_q     <= SEED;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            lfsr_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        sig_q     <= SEED;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        lfsr_en_q <= 1'b1;
                    end else if (shift_req) begin
                        sig_q <= shift_d;
                    end
                end
                ST_RUN: begin
                    if (resp_valid) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q   <= ST_DONE;
                            busy_q    <= 1'b0;
                            lfsr_en_q <= 1'b0;
                            done_q    <= 1'b1;
                            pass_q    <= (sig_d == golden);
                        end
                    end
                end
                ST_DONE: begin
                    // A restart takes priority over a pending serial shift
                    if (start) begin
                        state_q   <= ST_RUN;
                        sig_q     <= SEED;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        lfsr_en_q <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end else if (shift_req) begin
                        sig_q <= shift_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    pass_q    <= 1'b0;
                    lfsr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign signature = sig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign lfsr_en   = lfsr_en_q;

endmodule
